// File: rtl/spi_cs_arb_pkg.sv
// Shared types and sizing helpers for the SPI chip-select arbiter.
// Optional watchdog support in the top is enabled with SPI_CS_ARB_TIMEOUT_EN.
package spi_cs_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    // Width of a down-counter that must hold values 0..n (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of a requester index.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_cs_rr_pick.sv
// Round-robin selector: first set request at or after the pointer, wrapping.
// The pointer moves to (picked index + 1) mod NumReq on the advance strobe.
module spi_cs_rr_pick
    import spi_cs_arb_pkg::*;
#(
    parameter int NumReq = 2
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_sys_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic                          advance_i,
    output logic                          valid_o,
    output logic [idx_width(NumReq)-1:0]  idx_o
);

    localparam int              IdxW    = idx_width(NumReq);
    localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NumReq);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   cand_idx [NumReq];
    logic [NumReq-1:0] cand_hit;

    // Candidate gi is the requester gi positions after the pointer.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
        logic [IdxW:0] sum;
        assign sum          = {1'b0, ptr_q} + (IdxW + 1)'(gi);
        assign cand_idx[gi] = (sum >= NumReqW) ? IdxW'(sum - NumReqW) : sum[IdxW-1:0];
        assign cand_hit[gi] = req_i[cand_idx[gi]];
    end

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx[k];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (idx_o == LastIdx) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_cs_arbiter.sv
// Round-robin sharing of one SPI host and its chip select between NumReq requesters,
// with programmable CS setup/hold/gap. Define SPI_CS_ARB_TIMEOUT_EN for the grant watchdog.
module spi_cs_arbiter
    import spi_cs_arb_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int CsSetupCycles = 2,
    parameter int CsHoldCycles  = 2,
    parameter int IdleGapCycles = 1,
    parameter int TimeoutCycles = 65535
) (
    input  logic                          clk_sys_i,
    input  logic                          rst_sys_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             done_i,
    input  logic                          spi_idle_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [idx_width(NumReq)-1:0]  owner_o,
    output logic                          start_o,
    output logic                          busy_o,
    output logic                          cs_no,
    output logic                          timeout_o
);

    localparam int IdxW   = idx_width(NumReq);
    localparam int CntMax = (CsSetupCycles > CsHoldCycles)
                          ? ((CsSetupCycles > IdleGapCycles) ? CsSetupCycles : IdleGapCycles)
                          : ((CsHoldCycles > IdleGapCycles) ? CsHoldCycles : IdleGapCycles);
    localparam int CntW   = cnt_width(CntMax);

    localparam logic [CntW-1:0] SetupLoad = CntW'((CsSetupCycles > 0) ? CsSetupCycles - 1 : 0);
    localparam logic [CntW-1:0] HoldLoad  = CntW'((CsHoldCycles  > 0) ? CsHoldCycles  - 1 : 0);
    localparam logic [CntW-1:0] GapLoad   = CntW'((IdleGapCycles > 0) ? IdleGapCycles - 1 : 0);

    // Zero-length phases are skipped entirely rather than visited for a cycle.
    localparam state_e AfterIdle = (CsSetupCycles > 0) ? ST_SETUP : ST_ACTIVE;
    localparam state_e AfterHold = (IdleGapCycles > 0) ? ST_GAP : ST_IDLE;
    localparam state_e AfterXfer = (CsHoldCycles  > 0) ? ST_HOLD : AfterHold;

    if (NumReq < 2 || NumReq > 8) begin : g_bad_numreq
        $error("spi_cs_arbiter: NumReq must be in 2..8");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("spi_cs_arbiter: TimeoutCycles must be >= 1");
    end

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic              done_seen_q, done_seen_d;
    logic [NumReq-1:0] gnt_q, gnt_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              cs_n_q, cs_n_d;

    logic [NumReq-1:0] pick_req;
    logic              pick_valid;
    logic              pick_advance;
    logic [IdxW-1:0]   pick_idx;
    logic              owner_req;
    logic              owner_done;
    logic              act_exit;
    logic              wd_fire;

    assign owner_req  = req_i[owner_q];
    assign owner_done = done_i[owner_q];
    // Leaving ACTIVE always waits for the shifter, whether by done or by dropped request.
    assign act_exit   = spi_idle_i && (done_seen_q || owner_done || !owner_req);

    spi_cs_rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
        .req_i      (pick_req),
        .advance_i  (pick_advance),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

`ifdef SPI_CS_ARB_TIMEOUT_EN
    localparam int             WdW    = cnt_width(TimeoutCycles);
    localparam logic [WdW-1:0] WdLoad = WdW'(TimeoutCycles - 1);

    logic [WdW-1:0]    wd_q, wd_d;
    logic [NumReq-1:0] mask_q, mask_d;
    logic              timeout_q, timeout_d;

    // A timed-out requester stays masked until it has been seen with req_i low.
    assign pick_req = req_i & ~mask_q;
    assign wd_fire  = (state_q == ST_ACTIVE) && !act_exit && (wd_q == '0);

    always_comb begin
        wd_d      = wd_q;
        mask_d    = mask_q & req_i;
        timeout_d = wd_fire;
        if (state_q == ST_ACTIVE && wd_q != '0) begin
            wd_d = wd_q - 1'b1;
        end
        if (state_d == ST_ACTIVE && state_q != ST_ACTIVE) begin
            wd_d = WdLoad;
        end
        if (wd_fire) begin
            mask_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            wd_q      <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign pick_req  = req_i;
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        done_seen_d  = 1'b0;
        pick_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d      = pick_idx;
                    pick_advance = 1'b1;
                    state_d      = AfterIdle;
                end
            end
            ST_SETUP: begin
                if (!owner_req) begin
                    state_d = AfterXfer;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACTIVE: begin
                done_seen_d = done_seen_q || owner_done;
                if (act_exit || wd_fire) begin
                    state_d = AfterXfer;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = AfterHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            case (state_d)
                ST_SETUP: cnt_d = SetupLoad;
                ST_HOLD:  cnt_d = HoldLoad;
                ST_GAP:   cnt_d = GapLoad;
                default:  cnt_d = cnt_q;
            endcase
        end

        // Outputs are registered versions of what the next state implies.
        gnt_d   = (state_d == ST_ACTIVE) ? ({{(NumReq-1){1'b0}}, 1'b1} << owner_d) : '0;
        start_d = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
        busy_d  = (state_d != ST_IDLE);
        cs_n_d  = !((state_d == ST_SETUP) || (state_d == ST_ACTIVE) || (state_d == ST_HOLD));
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= '0;
            done_seen_q <= 1'b0;
            gnt_q       <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            done_seen_q <= done_seen_d;
            gnt_q       <= gnt_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;
    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign cs_no   = cs_n_q;

endmodule
